// File: rtl/fphub_pkg.sv
// Shared definitions for the single-precision HUB floating-point units
// (square and square root): field widths, exponent constants, the packed
// operand layout and the controller state encoding.
package fphub_pkg;

    localparam int EXP_W  = 8;
    localparam int MAN_W  = 23;
    localparam int WORD_W = 1 + EXP_W + MAN_W;
    localparam int SIG_W  = MAN_W + 2;           // {1, frac, ILSB}
    localparam int PROD_W = 2 * SIG_W;           // full significand product
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    // Exponent arithmetic runs two bits wider than the field so that
    // 2*e - BIAS + n can never wrap for any legal e.
    localparam int XEXP_W = EXP_W + 2;
    localparam logic signed [XEXP_W-1:0] BIAS_X     = XEXP_W'(BIAS);
    localparam logic signed [XEXP_W-1:0] EXP_ONES_X = {2'b00, EXP_ONES};
    localparam logic signed [XEXP_W-1:0] ZERO_X     = '0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fphub_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2
    } state_t;

    // HUB significand: hidden one, stored fraction, implicit LSB of one.
    function automatic logic [SIG_W-1:0] hub_sig(input logic [MAN_W-1:0] frac);
        return {1'b1, frac, 1'b1};
    endfunction

endpackage

// File: rtl/fphub_seq_mul.sv
// Unsigned radix-2 shift-add multiplier. One multiplier bit is retired per
// cycle, LSB first, so a W-bit product takes exactly W cycles after load.
// done_o is high during the cycle whose closing edge performs the final add,
// letting a controller step to its next state on that same edge.
module fphub_seq_mul #(
    parameter int W = 25
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [2*W-1:0] addend;

    // Partial product of this step: the shifted multiplicand gated by the
    // current multiplier LSB.
    for (genvar gi = 0; gi < 2 * W; gi++) begin : g_addend
        assign addend[gi] = mcand_q[gi] & mplier_q[0];
    end

    // Next-state: load restarts from a clean accumulator; otherwise one
    // shift-add step per cycle while busy.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (load_i) begin
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + addend;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    // State registers; reset abandons any product in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CNT_LAST);
    assign product_o = acc_q;

endmodule

// File: rtl/fphub_square.sv
// Iterative HUB single-precision squarer. Accepts an operand with a
// start/finish/computing handshake, squares the 25-bit HUB significand with
// the shift-add multiplier, then normalises and resolves special cases in
// one final cycle. Latency is fixed at MAN_W+3 cycles for every operand;
// rounding to nearest falls out of HUB truncation.
module fphub_square
    import fphub_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] res,
    output logic              finish,
    output logic              computing
);

    state_t            state_q, state_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [WORD_W-1:0] res_q, res_d;
    logic              finish_q, finish_d;
    logic              computing_q, computing_d;

    fphub_t            x_s;
    logic              mul_load;
    logic              mul_busy;
    logic              mul_done;
    logic [PROD_W-1:0] product;

    logic              prod_top;
    logic [MAN_W-1:0]  frac_n;
    logic signed [XEXP_W-1:0] exp_ext;
    logic signed [XEXP_W-1:0] exp_full;
    fphub_t            norm_res;
    logic              unused_bits;

    assign x_s      = x;
    assign mul_load = (state_q == IDLE) && start;

    fphub_seq_mul #(
        .W (SIG_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .load_i    (mul_load),
        .a_i       (hub_sig(x_s.frac)),
        .b_i       (hub_sig(x_s.frac)),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (product)
    );

    // Product lies in [1,4): the top bit selects a one-place normalisation.
    // Bits below the 23 kept fraction bits are simply dropped, and the sign
    // is irrelevant to a square.
    assign prod_top    = product[PROD_W-1];
    assign frac_n      = prod_top ? product[PROD_W-2 -: MAN_W]
                                  : product[PROD_W-3 -: MAN_W];
    assign exp_ext     = {2'b00, exp_q};
    assign exp_full    = (exp_ext <<< 1) - BIAS_X + {{(XEXP_W-1){1'b0}}, prod_top};
    assign unused_bits = ^{x_s.sign, product[PROD_W-MAN_W-3:0], mul_busy};

    // Result selection: zero and infinity inputs dominate, then exponent
    // overflow saturates to infinity and underflow flushes to zero.
    always_comb begin
        norm_res = '0;
        if (exp_q == '0) begin
            norm_res = '0;
        end else if (exp_q == EXP_ONES) begin
            norm_res.exp = EXP_ONES;
        end else if (exp_full >= EXP_ONES_X) begin
            norm_res.exp = EXP_ONES;
        end else if (exp_full <= ZERO_X) begin
            norm_res = '0;
        end else begin
            norm_res.exp  = exp_full[EXP_W-1:0];
            norm_res.frac = frac_n;
        end
    end

    // Controller: accept in IDLE, wait for the multiplier, then publish.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        res_d       = res_q;
        finish_d    = 1'b0;
        computing_d = computing_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = MUL;
                    exp_d       = x_s.exp;
                    computing_d = 1'b1;
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                res_d       = norm_res;
                finish_d    = 1'b1;
                computing_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller and output registers; reset aborts and clears the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            res_q       <= '0;
            finish_q    <= 1'b0;
            computing_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            res_q       <= res_d;
            finish_q    <= finish_d;
            computing_q <= computing_d;
        end
    end

    assign res       = res_q;
    assign finish    = finish_q;
    assign computing = computing_q;

endmodule
